// File: rtl/irq_edge_latch.sv
// Per-line interrupt edge latch: edge-mode lines latch rising edges until acked,
// level-mode lines pass through. CV32E41S_IRQ_SYNC_EN adds a 2-flop input synchronizer.
module irq_edge_latch #(
  parameter int unsigned OVF_CNT_W = 8,
  parameter logic [31:0] IRQ_MASK  = 32'hFFFF_0888
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          irq_raw_i,
  input  logic [31:0]          trig_edge_i,
  input  logic                 irq_ack_i,
  input  logic [4:0]           irq_ack_id_i,
  input  logic                 ovf_clr_i,
  output logic [31:0]          irq_o,
  output logic [31:0]          edge_pend_o,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

  logic [31:0]          w_s;
  logic [31:0]          w_edge;
  logic [31:0]          w_ack_hit;
  logic [31:0]          w_pend_nxt;
  logic [31:0]          w_lost;
  logic [31:0]          r_prev;
  logic [31:0]          r_edge_pend;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

`ifdef CV32E41S_IRQ_SYNC_EN
  logic [31:0] r_sync_meta;
  logic [31:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= irq_raw_i;
      r_sync      <= r_sync_meta;
    end
  end

  assign w_s = r_sync;
`else
  // Gated by reset so level lines cannot reach irq_o while the block is held in reset.
  assign w_s = irq_raw_i & {32{rst_n}};
`endif

  assign w_edge    = w_s & ~r_prev & trig_edge_i & IRQ_MASK;
  assign w_ack_hit = {32{irq_ack_i}} & (32'd1 << irq_ack_id_i) & trig_edge_i & IRQ_MASK;

  // A fresh edge beats a same-cycle ack; an edge onto a pending, un-acked line is lost.
  assign w_pend_nxt = trig_edge_i & (w_edge | (r_edge_pend & ~w_ack_hit));
  assign w_lost     = w_edge & r_edge_pend & ~w_ack_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_edge_pend <= '0;
    end else begin
      r_prev      <= w_s;
      r_edge_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr_i) begin
      r_ovf_cnt <= '0;
    end else if ((|w_lost) && (r_ovf_cnt != {OVF_CNT_W{1'b1}})) begin
      r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
    end
  end

  assign irq_o       = IRQ_MASK & ((trig_edge_i & r_edge_pend) | (~trig_edge_i & w_s));
  assign edge_pend_o = r_edge_pend;
  assign ovf_cnt_o   = r_ovf_cnt;

endmodule

// File: tb/tb_irq_edge_latch.sv
// Directed bench for irq_edge_latch; latencies follow CV32E41S_IRQ_SYNC_EN when defined.
module tb_irq_edge_latch;

`ifdef CV32E41S_IRQ_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_raw_i;
  logic [31:0] trig_edge_i;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;
  logic        ovf_clr_i;
  logic [31:0] irq_o;
  logic [31:0] edge_pend_o;
  logic [1:0]  ovf_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  irq_edge_latch #(.OVF_CNT_W(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_raw_i    (irq_raw_i),
    .trig_edge_i  (trig_edge_i),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_id_i (irq_ack_id_i),
    .ovf_clr_i    (ovf_clr_i),
    .irq_o        (irq_o),
    .edge_pend_o  (edge_pend_o),
    .ovf_cnt_o    (ovf_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Raise a line for one cycle; optional ack/clear are applied when the edge reaches s.
  task automatic edge_event(input int line, input logic ack, input logic clr);
    irq_raw_i[line] = 1'b1;
    for (int i = 0; i <= SD; i++) begin
      if (i == SD) begin
        irq_ack_i    = ack;
        irq_ack_id_i = 5'(line);
        ovf_clr_i    = clr;
      end
      tick();
      if (i == 0) irq_raw_i[line] = 1'b0;
      irq_ack_i = 1'b0;
      ovf_clr_i = 1'b0;
    end
    tick();
  endtask

  initial begin
    int exp_ovf[5] = '{1, 2, 3, 3, 3};
    rst_n        = 1'b0;
    irq_raw_i    = '0;
    trig_edge_i  = '0;
    irq_ack_i    = 1'b0;
    irq_ack_id_i = '0;
    ovf_clr_i    = 1'b0;
    #1;
    chk_val("rst_irq", irq_o, 32'h0);
    chk_val("rst_pend", edge_pend_o, 32'h0);
    chk_val("rst_ovf", 32'(ovf_cnt_o), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // level pass-through on line 11
    irq_raw_i[11] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) irq_raw_i[11] = 1'b0;
      #1;
      chk_val("lvl11", 32'(irq_o[11]), 32'((i >= SD) && (i < SD + 5)));
      tick();
    end
    chk_val("lvl11_nopend", edge_pend_o, 32'h0);

    trig_edge_i = 32'hFFFF_F7FF;
    tick();

    // edge line 7: latency, hold, ack
    irq_raw_i[7] = 1'b1;
    for (int i = 0; i <= SD; i++) begin
      #1;
      chk_val("e7_early", 32'(irq_o[7]), 32'h0);
      tick();
      if (i == 0) irq_raw_i[7] = 1'b0;
    end
    #1;
    chk_val("e7_rise", 32'(irq_o[7]), 32'h1);
    tick(); tick(); tick();
    chk_val("e7_hold", 32'(irq_o[7]), 32'h1);
    irq_ack_i    = 1'b1;
    irq_ack_id_i = 5'd7;
    #1;
    chk_val("e7_ackcyc", 32'(irq_o[7]), 32'h1);
    tick();
    irq_ack_i = 1'b0;
    #1;
    chk_val("e7_drop", 32'(irq_o[7]), 32'h0);
    chk_val("e7_pend", edge_pend_o, 32'h0);

    // line 16 pending, then edge coincident with ack
    edge_event(16, 1'b0, 1'b0);
    chk_val("e16_pend", edge_pend_o, 32'h0001_0000);
    edge_event(16, 1'b1, 1'b0);
    chk_val("e16_race_pend", edge_pend_o, 32'h0001_0000);
    chk_val("e16_race_irq", irq_o, 32'h0001_0000);
    chk_val("e16_race_ovf", 32'(ovf_cnt_o), 32'h0);

    // acks for level line 11 and unmasked line 12 change nothing
    irq_ack_i    = 1'b1;
    irq_ack_id_i = 5'd11;
    tick();
    irq_ack_id_i = 5'd12;
    tick();
    irq_ack_i = 1'b0;
    #1;
    chk_val("ack_ignored", edge_pend_o, 32'h0001_0000);

    // lost edges on line 3 saturate the 2-bit counter
    edge_event(3, 1'b0, 1'b0);
    chk_val("e3_first_ovf", 32'(ovf_cnt_o), 32'h0);
    for (int k = 0; k < 5; k++) begin
      edge_event(3, 1'b0, 1'b0);
      chk_val("ovf_sat", 32'(ovf_cnt_o), 32'(exp_ovf[k]));
    end
    edge_event(3, 1'b0, 1'b1);
    chk_val("ovf_clr_wins", 32'(ovf_cnt_o), 32'h0);
    chk_val("e3_still_pend", 32'(edge_pend_o[3]), 32'h1);

    // mode switch on line 30
    edge_event(30, 1'b0, 1'b0);
    chk_val("e30_irq", 32'(irq_o[30]), 32'h1);
    trig_edge_i[30] = 1'b0;
    tick();
    chk_val("e30_modeclr", 32'(edge_pend_o[30]), 32'h0);
    chk_val("e30_irq_lvl", 32'(irq_o[30]), 32'h0);
    trig_edge_i[30] = 1'b1;
    tick();
    chk_val("e30_nospur", 32'(edge_pend_o[30]), 32'h0);

    // line 12 is outside the mask, edge and level
    edge_event(12, 1'b0, 1'b0);
    chk_val("m12_irq_edge", 32'(irq_o[12]), 32'h0);
    chk_val("m12_pend", 32'(edge_pend_o[12]), 32'h0);
    trig_edge_i[12] = 1'b0;
    irq_raw_i[12]   = 1'b1;
    for (int i = 0; i <= SD; i++) tick();
    chk_val("m12_irq_lvl", 32'(irq_o[12]), 32'h0);
    irq_raw_i[12]   = 1'b0;
    trig_edge_i[12] = 1'b1;
    tick();

    // build 4 pending lines and ovf=2, then reset
    edge_event(20, 1'b0, 1'b0);
    edge_event(21, 1'b0, 1'b0);
    edge_event(20, 1'b0, 1'b0);
    edge_event(21, 1'b0, 1'b0);
    chk_val("pre_rst_ovf", 32'(ovf_cnt_o), 32'h2);
    chk_val("pre_rst_pend", edge_pend_o, 32'h0031_0008);
    chk_val("pre_rst_irq", irq_o, 32'h0031_0008);
    trig_edge_i[31] = 1'b1;
    irq_raw_i[31]   = 1'b1;
    irq_raw_i[11]   = 1'b1;
    rst_n           = 1'b0;
    #1;
    chk_val("mid_rst_irq", irq_o, 32'h0);
    chk_val("mid_rst_pend", edge_pend_o, 32'h0);
    chk_val("mid_rst_ovf", 32'(ovf_cnt_o), 32'h0);
    tick();
    chk_val("mid_rst_irq_hold", irq_o, 32'h0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i <= SD; i++) begin
      chk_val("r31_early", 32'(irq_o[31]), 32'h0);
      tick();
    end
    chk_val("r31_rise", 32'(irq_o[31]), 32'h1);
    chk_val("r11_level", 32'(irq_o[11]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of run expected finish before 100000 ns");
    $fatal(1);
  end

endmodule
